// File: rtl/relu_pool_engine_pkg.sv
// Shared types and size helpers for the ReLU + max-pool engine.
//   state_t    : engine control states
//   pool_tag_t : per-read tag travelling alongside RAM read latency
//   pool_oh/ow : pooled map height/width
//   pool_win   : number of samples in one pooling window
package relu_pool_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } pool_tag_t;

    function automatic int pool_oh(input int in_h, input int pool);
        return in_h / pool;
    endfunction

    function automatic int pool_ow(input int in_w, input int pool);
        return in_w / pool;
    endfunction

    function automatic int pool_win(input int pool);
        return pool * pool;
    endfunction

endpackage

// File: rtl/relu_pool_engine_tag_pipe.sv
// pool_tag_pipe: DEPTH-stage shift register carrying {valid, first, last}
// so each tag emerges in the same cycle as the RAM data it belongs to.
//   clk_i, rst_ni       : clock, async active-low reset (clears in-flight tags)
//   valid_i/first_i/last_i : tag of the read issued this cycle
//   valid_o/first_o/last_o : tag aligned with rd_data
module pool_tag_pipe
    import relu_pool_engine_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    input  logic first_i,
    input  logic last_i,
    output logic valid_o,
    output logic first_o,
    output logic last_o
);

    pool_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= '{valid: valid_i, first: first_i, last: last_i};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = stage_q[DEPTH-1].valid;
    assign first_o = stage_q[DEPTH-1].first;
    assign last_o  = stage_q[DEPTH-1].last;

endmodule

// File: rtl/relu_pool_engine.sv
// relu_pool_engine: reads an IN_H x IN_W map window by window through a
// synchronous-read RAM port, max-pools each POOL x POOL window, clamps at
// zero (signed mode) and emits one result per window at a sequential address.
//   clk, rst (async active-low)      : clock / reset
//   start                             : arm pulse, honoured only when idle
//   src_ready, src_done               : producer flow control (src_done sticky)
//   rd_en, rd_addr, rd_data           : RAM read port, data RD_LAT after rd_en
//   out_data, out_valid, out_addr     : pooled result strobe and write address
//   busy, done                        : run in progress / end-of-run pulse
module relu_pool_engine
    import relu_pool_engine_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SIGNED  = 1,
    parameter int IN_W    = 8,
    parameter int IN_H    = 8,
    parameter int POOL    = 2,
    parameter int RD_LAT  = 2,
    parameter int ADDR_W  = $clog2(IN_W * IN_H),
    parameter int OADDR_W = $clog2((IN_W / POOL) * (IN_H / POOL))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               src_ready,
    input  logic               src_done,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [OADDR_W-1:0] out_addr,
    output logic               busy,
    output logic               done
);

    localparam int OH   = pool_oh(IN_H, POOL);
    localparam int OW   = pool_ow(IN_W, POOL);
    localparam int WXW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int WYW  = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [2:0]         K_LAST     = 3'(POOL - 1);
    localparam logic [WXW-1:0]     WX_LAST    = WXW'(OW - 1);
    localparam logic [WYW-1:0]     WY_LAST    = WYW'(OH - 1);
    localparam logic [OADDR_W-1:0] OADDR_LAST = OADDR_W'(OH * OW - 1);
    // Address steps: next sample in row, next row inside a window,
    // next window to the right, first window of the next window row.
    localparam logic [ADDR_W-1:0]  STEP_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  STEP_ROW   = ADDR_W'(IN_W - POOL + 1);
    localparam logic [ADDR_W-1:0]  STEP_WIN   = ADDR_W'(POOL);
    localparam logic [ADDR_W-1:0]  STEP_WROW  = ADDR_W'((POOL - 1) * IN_W + POOL);

    state_t              state_q;
    logic [2:0]          kx_q, kx_d, ky_q, ky_d;
    logic [WXW-1:0]      wx_q, wx_d;
    logic [WYW-1:0]      wy_q, wy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
    logic                src_seen_q;
    logic                rd_en_q, tag_first_q, tag_last_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   acc_q, acc_d, relu_d, out_data_q;
    logic                out_valid_q, busy_q, done_q;
    logic [OADDR_W-1:0]  out_addr_q;

    logic issue, win_first, win_last, map_last, rd_gt;
    logic pipe_valid, pipe_first, pipe_last;

    pool_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_i   (clk),
        .rst_ni  (rst),
        .valid_i (rd_en_q),
        .first_i (tag_first_q),
        .last_i  (tag_last_q),
        .valid_o (pipe_valid),
        .first_o (pipe_first),
        .last_o  (pipe_last)
    );

    always_comb begin
        issue     = (state_q == S_RUN) && (src_ready || src_seen_q);
        win_first = (kx_q == '0) && (ky_q == '0);
        win_last  = (kx_q == K_LAST) && (ky_q == K_LAST);
        map_last  = win_last && (wx_q == WX_LAST) && (wy_q == WY_LAST);

        kx_d   = kx_q;
        ky_d   = ky_q;
        wx_d   = wx_q;
        wy_d   = wy_q;
        addr_d = addr_q;
        base_d = base_q;
        if (kx_q != K_LAST) begin
            kx_d   = kx_q + 3'd1;
            addr_d = addr_q + STEP_ONE;
        end else if (ky_q != K_LAST) begin
            kx_d   = '0;
            ky_d   = ky_q + 3'd1;
            addr_d = addr_q + STEP_ROW;
        end else begin
            kx_d = '0;
            ky_d = '0;
            if (wx_q != WX_LAST) begin
                wx_d   = wx_q + WXW'(1);
                base_d = base_q + STEP_WIN;
            end else begin
                wx_d   = '0;
                wy_d   = wy_q + WYW'(1);
                base_d = base_q + STEP_WROW;
            end
            addr_d = base_d;
        end

        rd_gt  = (SIGNED != 0) ? ($signed(rd_data) > $signed(acc_q)) : (rd_data > acc_q);
        acc_d  = (pipe_first || rd_gt) ? rd_data : acc_q;
        relu_d = ((SIGNED != 0) && acc_d[DATA_W-1]) ? '0 : acc_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            kx_q        <= '0;
            ky_q        <= '0;
            wx_q        <= '0;
            wy_q        <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            src_seen_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;

            // Address advances the cycle after each strobe and parks on the last slot.
            if (out_valid_q && (out_addr_q != OADDR_LAST)) begin
                out_addr_q <= out_addr_q + OADDR_W'(1);
            end

            // Accumulator only ever sees tagged data, so stalls cannot corrupt it.
            if (pipe_valid) begin
                acc_q <= acc_d;
                if (pipe_last) begin
                    out_data_q  <= relu_d;
                    out_valid_q <= 1'b1;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        busy_q     <= 1'b1;
                        kx_q       <= '0;
                        ky_q       <= '0;
                        wx_q       <= '0;
                        wy_q       <= '0;
                        addr_q     <= '0;
                        base_q     <= '0;
                        src_seen_q <= 1'b0;
                        out_addr_q <= '0;
                    end
                end
                S_RUN: begin
                    if (src_done) begin
                        src_seen_q <= 1'b1;
                    end
                    if (issue) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= addr_q;
                        tag_first_q <= win_first;
                        tag_last_q  <= win_last;
                        kx_q        <= kx_d;
                        ky_q        <= ky_d;
                        wx_q        <= wx_d;
                        wy_q        <= wy_d;
                        addr_q      <= addr_d;
                        base_q      <= base_d;
                        if (map_last) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_valid_q && (out_addr_q == OADDR_LAST)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_relu_pool_engine.sv
module tb_relu_pool_engine;

    localparam int NCFG = 5;

    // Configurations: map edge, pool edge, read latency, signed.
    function automatic int cfg_w(input int g);
        return (g <= 1) ? 4 : ((g == 2) ? 8 : 6);
    endfunction
    function automatic int cfg_p(input int g);
        return (g >= 3) ? 3 : 2;
    endfunction
    function automatic int cfg_l(input int g);
        return (g == 3) ? 1 : ((g == 4) ? 3 : 2);
    endfunction
    function automatic int cfg_s(input int g);
        return (g == 1 || g == 2 || g == 4) ? 1 : 0;
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic src_ready, src_done;
    logic [NCFG-1:0]       start_v;
    logic [NCFG-1:0]       rden_v, ov_v, busy_v, done_v;
    logic [NCFG-1:0][7:0]  ra_v, oa_v, od_v;
    logic [7:0]            mem [NCFG][64];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W  = cfg_w(g);
        localparam int P  = cfg_p(g);
        localparam int L  = cfg_l(g);
        localparam int S  = cfg_s(g);
        localparam int AW = $clog2(W * W);
        localparam int OW = $clog2((W / P) * (W / P));

        logic          rd_en, out_valid, busy, done;
        logic [AW-1:0] rd_addr;
        logic [OW-1:0] out_addr;
        logic [7:0]    rd_data, out_data;
        logic [7:0]    ram_q [L];

        relu_pool_engine #(
            .DATA_W  (8),
            .SIGNED  (S),
            .IN_W    (W),
            .IN_H    (W),
            .POOL    (P),
            .RD_LAT  (L),
            .ADDR_W  (AW),
            .OADDR_W (OW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .src_ready (src_ready),
            .src_done  (src_done),
            .rd_en     (rd_en),
            .rd_addr   (rd_addr),
            .rd_data   (rd_data),
            .out_data  (out_data),
            .out_valid (out_valid),
            .out_addr  (out_addr),
            .busy      (busy),
            .done      (done)
        );

        // RAM: data for a read appears L cycles after rd_en; junk otherwise.
        always @(posedge clk) begin
            ram_q[0] <= rd_en ? mem[g][int'(rd_addr)] : 8'hA5;
            for (int i = 1; i < L; i++) ram_q[i] <= ram_q[i-1];
        end
        assign rd_data   = ram_q[L-1];
        assign rden_v[g] = rd_en;
        assign ov_v[g]   = out_valid;
        assign busy_v[g] = busy;
        assign done_v[g] = done;
        assign ra_v[g]   = 8'(rd_addr);
        assign oa_v[g]   = 8'(out_addr);
        assign od_v[g]   = out_data;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic fill_random(input int c);
        for (int a = 0; a < 64; a++) begin
            mem[c][a] = 8'($urandom);
            if ($urandom_range(3, 0) != 0) mem[c][a][7] = 1'b1;
        end
    endtask

    // mode 0: src_ready high; 1: src_ready toggles every 3 cycles;
    // 2: random src_ready, one-cycle src_done pulse, then src_ready low.
    task automatic run_cfg(input int c, input int mode, input bit restart, input bit abort);
        int w, p, lat, sgn, oh, nout, k, cyc, dones, done_at, last_ov, maxoa, viol, sd_cyc;
        int best, v, a;
        int exp_a [64];
        bit prev_rdy, prev_sd, sd;
        w = cfg_w(c); p = cfg_p(c); lat = cfg_l(c); sgn = cfg_s(c);
        oh = w / p; nout = oh * oh;
        for (int wy = 0; wy < oh; wy++) begin
            for (int wx = 0; wx < oh; wx++) begin
                best = -1000;
                for (int ky = 0; ky < p; ky++) begin
                    for (int kx = 0; kx < p; kx++) begin
                        a = (wy * p + ky) * w + wx * p + kx;
                        v = (sgn != 0) ? int'($signed(mem[c][a])) : int'(mem[c][a]);
                        if (v > best) best = v;
                    end
                end
                exp_a[wy * oh + wx] = (best < 0) ? 0 : best;
            end
        end
        src_ready = 1'b1; src_done = 1'b0; sd = 1'b0;
        k = 0; cyc = 0; dones = 0; done_at = 0; last_ov = 0; maxoa = 0; viol = 0;
        sd_cyc = $urandom_range(60, 20);
        start_v = '0; start_v[c] = 1'b1;
        while (cyc < 3000) begin
            prev_rdy = src_ready; prev_sd = sd;
            @(posedge clk); #1; cyc++;
            if (cyc == 1) start_v = '0;
            if (restart && cyc == 8) start_v[c] = 1'b1;
            if (restart && cyc == 9) start_v = '0;
            if (cyc == 2) check("busy_run", busy_v[c], 1);
            if (rden_v[c] && !prev_rdy && !prev_sd) viol++;
            if (ov_v[c]) begin
                check("out_addr", oa_v[c], k);
                check("out_data", od_v[c], (k < 64) ? exp_a[k] : -1);
                if (mode == 0 && k > 0) check("out_spacing", cyc - last_ov, p * p);
                last_ov = cyc; k++;
            end
            if (int'(oa_v[c]) > maxoa) maxoa = oa_v[c];
            if (done_v[c]) begin
                dones++;
                if (dones == 1) begin
                    done_at = cyc;
                    check("done_after_last", k, nout);
                    if (mode == 0) check("done_cycle", cyc, w * w + lat + 3);
                end
            end
            if (abort && k == 1 && cyc == last_ov + 2) begin
                rst = 1'b0; #1;
                check("abort_rd_en", rden_v[c], 0);
                check("abort_rd_addr", ra_v[c], 0);
                check("abort_out_valid", ov_v[c], 0);
                check("abort_out_data", od_v[c], 0);
                check("abort_out_addr", oa_v[c], 0);
                check("abort_busy", busy_v[c], 0);
                check("abort_done", done_v[c], 0);
                #1 rst = 1'b1;
                return;
            end
            if (done_at != 0 && cyc >= done_at + 6) break;
            if (mode == 1) begin
                src_ready = ((cyc / 3) % 2) == 0;
            end else if (mode == 2) begin
                src_done = 1'b0;
                if (cyc == sd_cyc) begin
                    src_done = 1'b1; sd = 1'b1;
                end
                src_ready = sd ? 1'b0 : 1'($urandom_range(1, 0));
            end
        end
        src_ready = 1'b0; src_done = 1'b0;
        check("win_count", k, nout);
        check("done_count", dones, 1);
        check("max_out_addr", maxoa, nout - 1);
        check("busy_end", busy_v[c], 0);
        if (mode != 0) check("stall_reads", viol, 0);
    endtask

    initial begin
        rst = 1'b0; src_ready = 1'b0; src_done = 1'b0; start_v = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_v, 0);
        check("rst_done", done_v, 0);
        check("rst_rd_en", rden_v, 0);
        check("rst_out_valid", ov_v, 0);
        check("rst_rd_addr", ra_v[2], 0);
        check("rst_out_addr", oa_v[2], 0);
        check("rst_out_data", od_v[2], 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 64; a++) mem[0][a] = 8'(a);
        run_cfg(0, 0, 1'b0, 1'b0);
        fill_random(0);
        run_cfg(0, 0, 1'b0, 1'b0);

        for (int a = 0; a < 64; a++) mem[1][a] = (a == 10) ? 8'd4 : 8'hFD;
        run_cfg(1, 0, 1'b0, 1'b0);
        fill_random(1);
        run_cfg(1, 0, 1'b0, 1'b0);

        fill_random(2);
        run_cfg(2, 1, 1'b1, 1'b0);
        run_cfg(2, 2, 1'b0, 1'b0);
        run_cfg(2, 0, 1'b0, 1'b1);
        run_cfg(2, 0, 1'b0, 1'b0);

        fill_random(3);
        run_cfg(3, 0, 1'b0, 1'b0);
        fill_random(4);
        run_cfg(4, 0, 1'b0, 1'b0);
        run_cfg(4, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
